// File: rtl/vrf_mem_sequencer_if.sv
// vrf_mem_sequencer_if: control, memory and VRF write-port signals of the vector load/store engine.
interface vrf_mem_sequencer_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        vreg;
  logic [31:0]       vsrc_data;
  logic              busy;
  logic              done;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              vrf_write;
  logic [1:0]        vrf_wreg;
  logic [31:0]       vrf_wdata;
  modport master (
    output start, op, base_addr, vreg, vsrc_data, mem_rdata,
    input  busy, done, mem_re, mem_we, mem_addr, mem_wdata, vrf_write, vrf_wreg, vrf_wdata
  );
  modport slave (
    input  start, op, base_addr, vreg, vsrc_data, mem_rdata,
    output busy, done, mem_re, mem_we, mem_addr, mem_wdata, vrf_write, vrf_wreg, vrf_wdata
  );
endinterface

// File: rtl/vrf_mem_sequencer.sv
// vrf_mem_sequencer: moves a 32-bit vector word between the VRF and byte-wide memory, four little-endian bytes per operation.
module vrf_mem_sequencer #(parameter int ADDR_W = 8) (
  input logic clock,
  input logic reset,
  vrf_mem_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_LAST, LD_WB, ST_ISSUE, ST_DONE} state_t;
  state_t            state, next_state;
  logic [1:0]        cnt, prev_lane;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        vreg_q;
  logic [31:0]       data_q;
  // data_q holds the store word, or accumulates the load word lane by lane
  assign prev_lane = cnt - 2'd1;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      base_q <= '0;
      vreg_q <= '0;
      data_q <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (bus.start) begin
          cnt    <= '0;
          base_q <= bus.base_addr;
          vreg_q <= bus.vreg;
          data_q <= bus.vsrc_data;
        end
        LD_ISSUE: begin
          if (cnt != 2'd0) data_q[{prev_lane, 3'b000} +: 8] <= bus.mem_rdata;
          cnt <= cnt + 2'd1;
        end
        LD_LAST:  data_q[31:24] <= bus.mem_rdata;
        ST_ISSUE: cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end
  always_comb begin
    next_state    = state;
    bus.busy      = state != IDLE;
    bus.done      = state == LD_WB || state == ST_DONE;
    bus.mem_re    = state == LD_ISSUE;
    bus.mem_we    = state == ST_ISSUE;
    bus.mem_addr  = (state == LD_ISSUE || state == ST_ISSUE) ? base_q + ADDR_W'(cnt) : '0;
    bus.mem_wdata = state == ST_ISSUE ? data_q[{cnt, 3'b000} +: 8] : '0;
    bus.vrf_write = state == LD_WB;
    bus.vrf_wreg  = state == LD_WB ? vreg_q : '0;
    bus.vrf_wdata = state == LD_WB ? data_q : '0;
    case (state)
      IDLE:     next_state = bus.start ? (bus.op ? ST_ISSUE : LD_ISSUE) : IDLE;
      LD_ISSUE: next_state = cnt == 2'd3 ? LD_LAST : LD_ISSUE;
      LD_LAST:  next_state = LD_WB;
      ST_ISSUE: next_state = cnt == 2'd3 ? ST_DONE : ST_ISSUE;
      default:  next_state = IDLE;
    endcase
  end
endmodule

// File: doc/vrf_mem_sequencer.md
# vrf_mem_sequencer

Multicycle vector load/store engine that connects the 4×32-bit vector register file to the processor's 8-bit data memory. On a load it reads four consecutive bytes, packs them into a 32-bit vector word, and drives the register file's write port (vregw/vdataw/VRFWrite). On a store it takes a 32-bit word supplied from a register-file read port and writes it to memory as four consecutive bytes. The processor control FSM starts an operation and stalls until `done`.

## Interface
- ADDR_W, 8, memory address width; all address arithmetic is modulo 2^ADDR_W.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request; accepted only when `busy`=0.
- op  in  1  0 = vector load (memory→VRF), 1 = vector store (VRF→memory).
- base_addr  in  ADDR_W  address of byte 0 (lane 0).
- vreg  in  2  VRF destination register (load); informational for store.
- vsrc_data  in  32  store data from the VRF read port; sampled with `start`.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte, valid the cycle after `mem_re`.
- vrf_write  out  1  drives the VRF's VRFWrite.
- vrf_wreg  out  2  drives the VRF's vregw.
- vrf_wdata  out  32  drives the VRF's vdataw.

## Operation
- States: IDLE, LD_ISSUE, LD_LAST, LD_WB, ST_ISSUE, ST_DONE. A 2-bit lane counter `cnt` tracks the current lane.
- IDLE: if `start`=1, capture `op`, `base_addr`, `vreg` and `vsrc_data` at the clock edge and set `cnt`=0.
  - op=0 → LD_ISSUE.
  - op=1 → ST_ISSUE.
  - If `start`=0, remain in IDLE.
- Lane mapping is little-endian: lane i occupies bits [8i+7:8i] and lives at address base+i. The address wraps, so base 0xFE gives FE, FF, 00, 01.
- LD_ISSUE:
  - Assert `mem_re` with `mem_addr`=base+cnt.
  - When cnt>0, capture `mem_rdata` into lane cnt-1.
  - Increment `cnt`. After the cnt=3 cycle, go to LD_LAST.
- LD_LAST: `mem_re`=0. Capture `mem_rdata` into lane 3, then go to LD_WB.
- LD_WB:
  - Assert `vrf_write`=1, `vrf_wreg`=captured vreg, `vrf_wdata`=assembled word, and `done`=1.
  - The VRF commits the word at this edge. Go to IDLE.
- ST_ISSUE:
  - Assert `mem_we`=1 with `mem_addr`=base+cnt and `mem_wdata`=captured lane cnt.
  - Increment `cnt`. After cnt=3, go to ST_DONE.
- ST_DONE: `done`=1 with no memory activity, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy, including the `done` cycle, is ignored and does not queue. A new `start` is accepted only in the cycle after `done`.
- Inactive-value rules:
  - `mem_addr` and `mem_wdata` are 0 whenever `mem_re` and `mem_we` are both 0.
  - `vrf_wreg` and `vrf_wdata` are 0 whenever `vrf_write`=0.
  - `mem_re` and `mem_we` are never high together.
- The `vsrc_data` captured at `start` is used for the whole store. Later changes on the VRF read port have no effect.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE. All outputs are registered or decoded from state and registers; there is no combinational path from inputs to outputs.
- Load timeline:
  - Cycles 1–4: `mem_re`=1, addresses base+0..base+3.
  - Bytes 0–3 arrive in cycles 2–5.
  - Cycle 6: `vrf_write`=1 and `done`=1.
  - `busy` is high in cycles 1–6. Latency from start to done is 6 cycles.
- Store timeline:
  - Cycles 1–4: `mem_we`=1, bytes lane0..lane3.
  - Cycle 5: `done`=1.
  - `busy` is high in cycles 1–5.
- Back-to-back: earliest next `start` is in cycle 7 for a load and cycle 6 for a store.
- Reset (asynchronous) forces IDLE and `cnt`=0, clears the captured registers, and sets every output to 0.
  - Reset mid-load: no `vrf_write` is issued.
  - Reset mid-store: bytes already written stay in memory, and no further writes occur.
  - After reset deasserts, the first `start` is accepted normally.

## Test plan
- Load, base=0x10, memory[10..13]=11,22,33,44, vreg=2 → `mem_re` cycles 1–4 at addresses 10–13; cycle 6 shows `vrf_write`=1, `vrf_wreg`=2, `vrf_wdata`=0x44332211, `done`=1; VRF r2 reads 0x44332211.
- Store, base=0x20, vsrc_data=0xDEADBEEF → `mem_we` cycles 1–4 writing EF, BE, AD, DE to addresses 20–23; `done` in cycle 5; `vrf_write` never asserted.
- Wrap-around: load with base=0xFE → addresses FE, FF, 00, 01 in cycles 1–4; assembled word lane order is preserved.
- `start` pulsed in cycles 3 and 6 during a load → both ignored, exactly one `done`; `start` in cycle 7 is accepted.
- Reset in cycle 3 of a store → outputs go to 0 immediately; only bytes 0–1 are written; no `done`; the next store completes with the full 5-cycle timeline.
- `vsrc_data` changed in cycle 2 of a store → memory still receives the bytes captured in cycle 0.
